seq_gen_1011: RTL

SEQ_GEN_1011 -- requirements
Module: seq_gen_1011

---
 rtl/seq_gen_1011.sv | 95 +++++++++
 1 files changed

// File: rtl/seq_gen_1011.sv
// seq_gen_1011: emits bursts of the serial pattern 1011 with
// optional zero gaps, for driving a 1011 sequence detector.
module seq_gen_1011 #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             start_i,
  input  logic [3:0]       num_i,
  input  logic [2:0]       gap_i,
  output logic             input_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sent_cnt_o
);

  typedef enum logic [6:0] {
    S_IDLE = 7'b000_0001,
    S_P1   = 7'b000_0010,
    S_P0   = 7'b000_0100,
    S_P1B  = 7'b000_1000,
    S_P1C  = 7'b001_0000,
    S_GAP  = 7'b010_0000,
    S_FIN  = 7'b100_0000
  } state_t;

  state_t           r_state;
  logic [3:0]       r_rem;
  logic [2:0]       r_gap;
  logic [2:0]       r_gap_cnt;
  logic [CNT_W-1:0] r_sent_cnt;

  // Burst sequencer: state, remaining patterns, gap timer, pattern count
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
      r_sent_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (num_i != 4'd0) begin
              r_rem   <= num_i;
              r_gap   <= gap_i;
              r_state <= S_P1;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_P1:  r_state <= S_P0;
        S_P0:  r_state <= S_P1B;
        S_P1B: r_state <= S_P1C;
        S_P1C: begin
          r_rem      <= r_rem - 4'd1;
          r_sent_cnt <= r_sent_cnt + 1'b1;
          if (r_rem == 4'd1) begin
            r_state <= S_FIN;
          end else if (r_gap == 3'd0) begin
            r_state <= S_P1;
          end else begin
            r_gap_cnt <= r_gap;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          // Count <=1 also guards against a stray zero load
          if (r_gap_cnt <= 3'd1) begin
            r_gap_cnt <= '0;
            r_state   <= S_P1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 3'd1;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded straight from the one-hot state flops
  assign input_o    = (r_state == S_P1) | (r_state == S_P1B) |
                      (r_state == S_P1C);
  assign valid_o    = (r_state == S_P1) | (r_state == S_P0) |
                      (r_state == S_P1B) | (r_state == S_P1C) |
                      (r_state == S_GAP);
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_FIN);
  assign sent_cnt_o = r_sent_cnt;

endmodule
